// File: rtl/sll_seq.sv
// rtl/sll_seq.sv - multi-cycle shift-left-logical unit with start/busy/done handshake
// Shifts rt left by shamt, at most STEP bits per clock, and flags any 1 shifted out of the MSB.
module sll_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] rt,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd,
  output logic             lost
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_top_mask;
  logic [WIDTH-1:0] r_rd;
  logic [SHW:0]     r_cnt;
  logic [SHW:0]     w_cnt_next;
  logic [SHW:0]     w_k;
  logic             r_lost_acc;
  logic             w_lost_next;
  logic             r_lost;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_lost_next  = r_lost_acc;
    // k = min(STEP, cnt); the mask selects the k bits about to leave the MSB
    w_k          = (r_cnt < STEP_W) ? r_cnt : STEP_W;
    w_top_mask   = ~({WIDTH{1'b1}} >> w_k);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_next   = rt;
          w_cnt_next   = {1'b0, shamt};
          w_lost_next  = 1'b0;
          w_state_next = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_lost_next = r_lost_acc | (|(r_acc & w_top_mask));
        w_acc_next  = r_acc << w_k;
        w_cnt_next  = r_cnt - w_k;
        if (w_cnt_next == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so busy/done align with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_lost_acc <= 1'b0;
      r_rd       <= '0;
      r_lost     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_acc      <= w_acc_next;
      r_cnt      <= w_cnt_next;
      r_lost_acc <= w_lost_next;
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= (w_state_next == S_DONE);
      if (w_state_next == S_DONE) begin
        r_rd   <= w_acc_next;
        r_lost <= w_lost_next;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign rd   = r_rd;
  assign lost = r_lost;

endmodule

// File: tb/tb_sll_seq.sv
// tb/tb_sll_seq.sv - self-checking bench for sll_seq with STEP=1 and STEP=4 instances
// Expected results come from a 64-bit reference shift; latency from ceil(shamt/STEP).
module tb_sll_seq;

  logic        clk;
  logic        rst_n;
  logic        start1;
  logic        start4;
  logic [31:0] rt;
  logic [4:0]  shamt;
  logic        busy1, done1, lost1;
  logic        busy4, done4, lost4;
  logic [31:0] rd1, rd4;

  int errors;
  int checks;

  sll_seq #(.WIDTH(32), .SHW(5), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rt(rt), .shamt(shamt),
    .busy(busy1), .done(done1), .rd(rd1), .lost(lost1)
  );

  sll_seq #(.WIDTH(32), .SHW(5), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .rt(rt), .shamt(shamt),
    .busy(busy4), .done(done4), .rd(rd4), .lost(lost4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_sll(input logic [31:0] a, input logic [4:0] s,
                                  output logic [31:0] r, output logic l);
    logic [63:0] full;
    full = {32'd0, a} << s;
    r    = full[31:0];
    l    = |full[63:32];
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input string tag);
    logic [31:0] exp_rd, g1, g4;
    logic        exp_l, l1, l4;
    int lat1, lat4, c1, c4, n1, n4, b1;
    ref_sll(a, s, exp_rd, exp_l);
    lat1 = int'(s);
    lat4 = (int'(s) + 3) / 4;
    c1 = -1; c4 = -1; n1 = 0; n4 = 0; b1 = 0;
    g1 = '0; g4 = '0; l1 = 1'b0; l4 = 1'b0;
    rt = a; shamt = s; start1 = 1'b1; start4 = 1'b1;
    step();
    start1 = 1'b0; start4 = 1'b0;
    rt = $urandom; shamt = 5'($urandom);
    for (int c = 0; c < 40; c++) begin
      if (busy1) b1++;
      if (done1) begin n1++; if (c1 < 0) c1 = c; g1 = rd1; l1 = lost1; end
      if (done4) begin n4++; if (c4 < 0) c4 = c; g4 = rd4; l4 = lost4; end
      step();
    end
    checks += 9;
    if (n1 !== 1) begin errors++; $display("FAIL %s done1_pulses got %0d exp 1", tag, n1); end
    if (n4 !== 1) begin errors++; $display("FAIL %s done4_pulses got %0d exp 1", tag, n4); end
    if (c1 !== lat1) begin errors++; $display("FAIL %s latency1 got %0d exp %0d", tag, c1, lat1); end
    if (c4 !== lat4) begin errors++; $display("FAIL %s latency4 got %0d exp %0d", tag, c4, lat4); end
    if (g1 !== exp_rd || l1 !== exp_l) begin
      errors++; $display("FAIL %s rd1/lost1 got %h/%b exp %h/%b", tag, g1, l1, exp_rd, exp_l);
    end
    if (g4 !== exp_rd || l4 !== exp_l) begin
      errors++; $display("FAIL %s rd4/lost4 got %h/%b exp %h/%b", tag, g4, l4, exp_rd, exp_l);
    end
    if (b1 !== lat1 + 1) begin errors++; $display("FAIL %s busy1_cycles got %0d exp %0d", tag, b1, lat1 + 1); end
    if (rd1 !== exp_rd) begin errors++; $display("FAIL %s rd1_hold got %h exp %h", tag, rd1, exp_rd); end
    if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL %s idle_after got %b/%b exp 0/0", tag, busy1, busy4);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; rt = '0; shamt = '0;
    step(); step();
    checks += 2;
    if ({busy1, done1, rd1, lost1} !== 35'd0) begin
      errors++; $display("FAIL reset_dut1 got b=%b d=%b rd=%h l=%b exp all 0", busy1, done1, rd1, lost1);
    end
    if ({busy4, done4, rd4, lost4} !== 35'd0) begin
      errors++; $display("FAIL reset_dut4 got b=%b d=%b rd=%h l=%b exp all 0", busy4, done4, rd4, lost4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(32'h0000FFFF, 5'd1,  "vec1");
    run_op(32'h87FFFFE0, 5'd3,  "vec2");
    run_op(32'h07C1FFE0, 5'd31, "vec3");
    run_op(32'hDEADBEEF, 5'd0,  "vec4");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op($urandom, 5'($urandom_range(0, 31)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_start_held();
    int n, c_done;
    n = 0; c_done = -1;
    rt = 32'hDEADBEEF; shamt = 5'd0; start1 = 1'b1;
    step();
    for (int c = 0; c < 10; c++) begin
      if (done1) begin
        n++;
        if (c_done < 0) begin c_done = c; start1 = 1'b0; end
      end
      step();
    end
    start1 = 1'b0;
    checks += 3;
    if (n !== 1) begin errors++; $display("FAIL held_accepts got %0d exp 1", n); end
    if (c_done !== 0) begin errors++; $display("FAIL held_latency got %0d exp 0", c_done); end
    if (rd1 !== 32'hDEADBEEF || lost1 !== 1'b0) begin
      errors++; $display("FAIL held_rd got %h/%b exp deadbeef/0", rd1, lost1);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    n = 0;
    rt = 32'hFFFF_FFFF; shamt = 5'd20; start1 = 1'b1; start4 = 1'b1;
    step();
    start1 = 1'b0; start4 = 1'b0;
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    checks += 2;
    if ({busy1, done1, rd1, lost1} !== 35'd0) begin
      errors++; $display("FAIL midreset_dut1 got b=%b d=%b rd=%h l=%b exp all 0", busy1, done1, rd1, lost1);
    end
    if ({busy4, done4, rd4, lost4} !== 35'd0) begin
      errors++; $display("FAIL midreset_dut4 got b=%b d=%b rd=%h l=%b exp all 0", busy4, done4, rd4, lost4);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (done1 || done4 || busy1 || busy4) n++;
      step();
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles exp 0", n); end
    run_op(32'h1, 5'd4, "after_reset");
  endtask

  task automatic test_back_to_back();
    int nd, c_first, c_second, idle_gap;
    logic [31:0] r_first, r_second;
    logic l_first, l_second;
    nd = 0; c_first = -1; c_second = -1; idle_gap = 0;
    r_first = '0; r_second = '0; l_first = 1'b1; l_second = 1'b1;
    rt = 32'h1; shamt = 5'd31; start1 = 1'b1;
    step();
    rt = 32'h3; shamt = 5'd30;
    for (int c = 0; c < 75; c++) begin
      if (done1) begin
        nd++;
        if (nd == 1) begin c_first = c; r_first = rd1; l_first = lost1; end
        if (nd == 2) begin c_second = c; r_second = rd1; l_second = lost1; start1 = 1'b0; end
      end
      if (nd == 1 && !busy1) idle_gap++;
      step();
    end
    start1 = 1'b0;
    checks += 6;
    if (nd !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", nd); end
    if (c_first !== 31) begin errors++; $display("FAIL b2b_first_latency got %0d exp 31", c_first); end
    if (r_first !== 32'h80000000 || l_first !== 1'b0) begin
      errors++; $display("FAIL b2b_first_rd got %h/%b exp 80000000/0", r_first, l_first);
    end
    if (c_second !== 63) begin errors++; $display("FAIL b2b_second_latency got %0d exp 63", c_second); end
    if (r_second !== 32'hC0000000 || l_second !== 1'b0) begin
      errors++; $display("FAIL b2b_second_rd got %h/%b exp c0000000/0", r_second, l_second);
    end
    if (idle_gap !== 1) begin errors++; $display("FAIL b2b_idle_gap got %0d exp 1", idle_gap); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
